fetch_sequencer: RTL

- Parametrised front-end controller for the multicycle MIPS datapath. Owns fetch, PC+4, IR load, decode/register read and exception entry.
- Hands decoded instructions to the per-instruction execute FSM through a valid/done handshake.
- Generalises the fixed common-fetch sequence: configurable memory wait states, configurable PC step and vector base, N prioritised exception causes with EPC save and vectored handler load.

---
 rtl/fetch_sequencer_pkg.sv | 57 +++++
 rtl/fetch_sequencer_mem_wait_counter.sv | 31 +++
 rtl/fetch_sequencer.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_pkg.sv
// rtl/fetch_sequencer_pkg.sv - shared encodings and helpers for the multicycle fetch front end
package fetch_sequencer_pkg;

  typedef enum logic [3:0] {
    RESET_HOLD = 4'd0,
    FETCH_ADDR = 4'd1,
    FETCH_WAIT = 4'd2,
    IR_LOAD    = 4'd3,
    DECODE     = 4'd4,
    DISPATCH   = 4'd5,
    EXC_EPC    = 4'd6,
    EXC_WAIT   = 4'd7,
    EXC_LOAD   = 4'd8
  } state_e;

  localparam logic [2:0] PCSRC_ALU      = 3'b000;
  localparam logic [2:0] PCSRC_MEMBYTE  = 3'b011;
  localparam logic [1:0] IORD_PC        = 2'b00;
  localparam logic [1:0] IORD_VEC       = 2'b10;
  localparam logic [1:0] ALUSRCB_BRANCH = 2'b11;
  localparam logic [2:0] ALUOP_ADD      = 3'b001;
  localparam logic [2:0] ALUOP_SUB      = 3'b010;

  localparam int unsigned EXC_OPCODE = 0;
  localparam int unsigned EXC_OVFL   = 1;
  localparam int unsigned EXC_DIV0   = 2;

  typedef struct packed {
    logic       reset_signal;
    logic [2:0] pc_src;
    logic [1:0] iord;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       pc_write;
    logic       ir_write;
    logic       a_write;
    logic       b_write;
    logic       aluout_write;
    logic       epc_write;
    logic       mem_wr;
    logic       dispatch_valid;
  } ctrl_t;

  localparam ctrl_t CTRL_RESET = '{reset_signal: 1'b1, default: '0};

  // Lowest set bit wins, so cause 0 has the highest priority.
  function automatic int unsigned lowest_set(input logic [31:0] v);
    int unsigned idx;
    idx = 0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) idx = unsigned'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/fetch_sequencer_mem_wait_counter.sv
// rtl/fetch_sequencer_mem_wait_counter.sv - memory wait-state down counter shared by fetch and exception reads
module mem_wait_counter #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) count_q <= '0;
    else         count_q <= count_d;
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - fetch/decode/exception-entry controller for the multicycle MIPS datapath
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int unsigned MEM_WAIT    = 1,
  parameter logic [1:0]  PC_STEP_SEL = 2'b01,
  parameter int unsigned NUM_EXC     = 3,
  parameter logic [7:0]  VEC_BASE    = 8'd253,
  localparam int unsigned CAUSE_W    = (NUM_EXC > 1) ? $clog2(NUM_EXC) : 1
) (
  input  logic               Clock_i,
  input  logic               Reset_ni,
  input  logic               Op_Valid_i,
  input  logic               Exec_Done_i,
  input  logic [NUM_EXC-1:0] Exc_Req_i,
  output logic               Reset_Signal_o,
  output logic [2:0]         PC_Src_o,
  output logic [1:0]         IorD_o,
  output logic               ALU_SrcA_o,
  output logic [1:0]         ALU_SrcB_o,
  output logic [2:0]         ALU_Op_o,
  output logic               PC_Write_o,
  output logic               IR_Write_o,
  output logic               A_Write_o,
  output logic               B_Write_o,
  output logic               ALUOut_Write_o,
  output logic               EPC_Write_o,
  output logic               Mem_WR_o,
  output logic               Dispatch_Valid_o,
  output logic [7:0]         Exc_Vector_o,
  output logic [CAUSE_W-1:0] Exc_Cause_o
);

  localparam int unsigned CNT_W     = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;
  localparam int unsigned WAIT_LOAD = (MEM_WAIT > 0) ? MEM_WAIT - 1 : 0;

  state_e             state_q, state_d;
  logic               hold_done_q;
  logic [CAUSE_W-1:0] cause_q, cause_d;
  ctrl_t              ctrl_q, ctrl_d;
  logic [7:0]         vec_q, vec_d;
  logic               cnt_load, cnt_dec, cnt_zero;

  mem_wait_counter #(.WIDTH(CNT_W)) u_wait (
    .clk_i      (Clock_i),
    .rst_ni     (Reset_ni),
    .load_i     (cnt_load),
    .load_val_i (CNT_W'(WAIT_LOAD)),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge Clock_i or negedge Reset_ni) begin
    if (!Reset_ni) begin
      state_q     <= RESET_HOLD;
      hold_done_q <= 1'b0;
      cause_q     <= '0;
      ctrl_q      <= CTRL_RESET;
      vec_q       <= '0;
    end else begin
      state_q     <= state_d;
      hold_done_q <= 1'b1;
      cause_q     <= cause_d;
      ctrl_q      <= ctrl_d;
      vec_q       <= vec_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cause_d  = cause_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (state_q)
      RESET_HOLD: if (hold_done_q) state_d = FETCH_ADDR;
      FETCH_ADDR: begin
        cnt_load = 1'b1;
        state_d  = (MEM_WAIT > 0) ? FETCH_WAIT : IR_LOAD;
      end
      FETCH_WAIT: begin
        if (cnt_zero) state_d = IR_LOAD;
        else          cnt_dec = 1'b1;
      end
      IR_LOAD: state_d = DECODE;
      DECODE: begin
        if (!Op_Valid_i) begin
          cause_d = CAUSE_W'(EXC_OPCODE);
          state_d = EXC_EPC;
        end else begin
          state_d = DISPATCH;
        end
      end
      DISPATCH: begin
        if (|Exc_Req_i) begin
          cause_d = CAUSE_W'(lowest_set(32'(Exc_Req_i)));
          state_d = EXC_EPC;
        end else if (Exec_Done_i) begin
          state_d = FETCH_ADDR;
        end
      end
      EXC_EPC: begin
        cnt_load = 1'b1;
        state_d  = (MEM_WAIT > 0) ? EXC_WAIT : EXC_LOAD;
      end
      EXC_WAIT: begin
        if (cnt_zero) state_d = EXC_LOAD;
        else          cnt_dec = 1'b1;
      end
      EXC_LOAD: state_d = FETCH_ADDR;
      default:  state_d = FETCH_ADDR;
    endcase
  end

  always_comb begin
    ctrl_d = '0;
    vec_d  = '0;
    case (state_d)
      RESET_HOLD: ctrl_d.reset_signal = 1'b1;
      FETCH_ADDR: begin
        ctrl_d.iord      = IORD_PC;
        ctrl_d.alu_src_b = PC_STEP_SEL;
        ctrl_d.alu_op    = ALUOP_ADD;
        ctrl_d.pc_write  = 1'b1;
      end
      IR_LOAD: ctrl_d.ir_write = 1'b1;
      DECODE: begin
        ctrl_d.a_write      = 1'b1;
        ctrl_d.b_write      = 1'b1;
        ctrl_d.aluout_write = 1'b1;
        ctrl_d.alu_src_b    = ALUSRCB_BRANCH;
        ctrl_d.alu_op       = ALUOP_ADD;
      end
      DISPATCH: ctrl_d.dispatch_valid = 1'b1;
      EXC_EPC: begin
        ctrl_d.alu_src_b = PC_STEP_SEL;
        ctrl_d.alu_op    = ALUOP_SUB;
        ctrl_d.epc_write = 1'b1;
        ctrl_d.iord      = IORD_VEC;
        vec_d            = VEC_BASE + 8'(cause_d);
      end
      EXC_WAIT: begin
        ctrl_d.iord = IORD_VEC;
        vec_d       = VEC_BASE + 8'(cause_d);
      end
      EXC_LOAD: begin
        ctrl_d.pc_src   = PCSRC_MEMBYTE;
        ctrl_d.pc_write = 1'b1;
        vec_d           = VEC_BASE + 8'(cause_d);
      end
      default: ;
    endcase
  end

  assign Reset_Signal_o   = ctrl_q.reset_signal;
  assign PC_Src_o         = ctrl_q.pc_src;
  assign IorD_o           = ctrl_q.iord;
  assign ALU_SrcA_o       = ctrl_q.alu_src_a;
  assign ALU_SrcB_o       = ctrl_q.alu_src_b;
  assign ALU_Op_o         = ctrl_q.alu_op;
  assign PC_Write_o       = ctrl_q.pc_write;
  assign IR_Write_o       = ctrl_q.ir_write;
  assign A_Write_o        = ctrl_q.a_write;
  assign B_Write_o        = ctrl_q.b_write;
  assign ALUOut_Write_o   = ctrl_q.aluout_write;
  assign EPC_Write_o      = ctrl_q.epc_write;
  assign Mem_WR_o         = ctrl_q.mem_wr;
  assign Dispatch_Valid_o = ctrl_q.dispatch_valid;
  assign Exc_Vector_o     = vec_q;
  assign Exc_Cause_o      = cause_q;

endmodule
